// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive framing controller: SYNC/ADDR/LEN/PAYLOAD/CHK frame parser
// with payload buffering, XOR checksum, inter-byte timeout and replay stream.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 130200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_byte,
    input  logic       i_byte_valid,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    input  logic       i_data_ready,
    output logic       o_data_last,
    output logic       o_pkt_ok,
    output logic [7:0] o_pkt_addr,
    output logic [7:0] o_pkt_len,
    output logic       o_err_chk,
    output logic       o_err_len,
    output logic       o_err_timeout,
    output logic       o_err_overrun,
    output logic [7:0] o_err_cnt
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      chk_q, chk_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            pkt_ok_q, pkt_ok_d;
    logic [7:0]      pkt_addr_q, pkt_addr_d;
    logic [7:0]      pkt_len_q, pkt_len_d;
    logic            err_chk_q, err_chk_d;
    logic            err_len_q, err_len_d;
    logic            err_tmo_q, err_tmo_d;
    logic            err_ovr_q, err_ovr_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [7:0]      pbuf_q [MAX_LEN];
    logic            buf_we;
    logic [AW-1:0]   buf_wa;
    logic [AW-1:0]   rd_addr;
    logic [7:0]      rd_data;
    logic            in_frame;
    logic            any_err;

    // Read port: buf[0] when accepting the checksum, next beat while draining.
    always_comb begin
        rd_addr = '0;
        if (state_q == S_DRAIN) begin
            rd_addr = AW'(idx_q + 8'd1);
        end
        rd_data = pbuf_q[rd_addr];
    end

    // Next-state and output logic for the frame parser and replay stream.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        chk_d      = chk_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        valid_d    = valid_q;
        last_d     = last_q;
        pkt_ok_d   = 1'b0;
        pkt_addr_d = pkt_addr_q;
        pkt_len_d  = pkt_len_q;
        err_chk_d  = 1'b0;
        err_len_d  = 1'b0;
        err_tmo_d  = 1'b0;
        err_ovr_d  = 1'b0;
        buf_we     = 1'b0;
        buf_wa     = idx_q[AW-1:0];
        in_frame   = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (i_byte_valid && i_byte == SYNC_BYTE) begin
                    state_d = S_ADDR;
                    chk_d   = '0;
                end
            end
            S_ADDR: begin
                in_frame = 1'b1;
                if (i_byte_valid) begin
                    addr_d  = i_byte;
                    chk_d   = i_byte;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                in_frame = 1'b1;
                if (i_byte_valid) begin
                    len_d = i_byte;
                    chk_d = chk_q ^ i_byte;
                    idx_d = '0;
                    if (i_byte > MAX_LEN_B) begin
                        err_len_d = 1'b1;
                        state_d   = S_HUNT;
                    end else if (i_byte == 8'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                in_frame = 1'b1;
                if (i_byte_valid) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ i_byte;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = S_CHK;
                    end
                end
            end
            S_CHK: begin
                in_frame = 1'b1;
                if (i_byte_valid) begin
                    if (i_byte == chk_q) begin
                        pkt_ok_d   = 1'b1;
                        pkt_addr_d = addr_q;
                        pkt_len_d  = len_q;
                        if (len_q != 8'd0) begin
                            state_d = S_DRAIN;
                            valid_d = 1'b1;
                            data_d  = rd_data;
                            last_d  = (len_q == 8'd1);
                            idx_d   = '0;
                        end else begin
                            state_d = S_HUNT;
                        end
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (i_byte_valid) begin
                    err_ovr_d = 1'b1;
                end
                if (valid_q && i_data_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = S_HUNT;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        data_d = rd_data;
                        last_d = ((idx_q + 8'd1) == (len_q - 8'd1));
                    end
                end
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase

        if (in_frame) begin
            if (i_byte_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d     = '0;
                err_tmo_d = 1'b1;
                state_d   = S_HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end

        any_err   = err_chk_d | err_len_d | err_tmo_d | err_ovr_d;
        err_cnt_d = err_cnt_q;
        if (any_err && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_HUNT;
            addr_q     <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            chk_q      <= '0;
            tmo_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            pkt_addr_q <= '0;
            pkt_len_q  <= '0;
            err_chk_q  <= 1'b0;
            err_len_q  <= 1'b0;
            err_tmo_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            chk_q      <= chk_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_addr_q <= pkt_addr_d;
            pkt_len_q  <= pkt_len_d;
            err_chk_q  <= err_chk_d;
            err_len_q  <= err_len_d;
            err_tmo_q  <= err_tmo_d;
            err_ovr_q  <= err_ovr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Payload buffer write port; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (buf_we) begin
            pbuf_q[buf_wa] <= i_byte;
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = valid_q;
    assign o_data_last   = last_q;
    assign o_pkt_ok      = pkt_ok_q;
    assign o_pkt_addr    = pkt_addr_q;
    assign o_pkt_len     = pkt_len_q;
    assign o_err_chk     = err_chk_q;
    assign o_err_len     = err_len_q;
    assign o_err_timeout = err_tmo_q;
    assign o_err_overrun = err_ovr_q;
    assign o_err_cnt     = err_cnt_q;

endmodule
